// File: rtl/reg_dump_reader.sv
// Debug read-out engine: halts the core, walks a register index range through one
// register-file read port and streams {index, data} beats to a valid/ready sink.
module reg_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a beat transfers on a rising edge where dump_valid && dump_ready.
  // Once raised, dump_valid and the beat payload hold until that transfer (or an abort).
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_READ      = 3'd2,
    S_SEND      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last_idx;
  logic                r_halt_req;
  logic                r_dump_valid;
  logic [ADDR_W-1:0]   r_dump_index;
  logic [DATA_W-1:0]   r_dump_data;
  logic                r_dump_last;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_reject;
  logic                w_abort;
  logic                w_load_beat;
  logic                w_handshake;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_abort      = 1'b0;
    w_load_beat  = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (first_idx <= last_idx) begin
            w_accept     = 1'b1;
            w_next_state = S_HALT_WAIT;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_HALT_WAIT: begin
        if (halt_ack) w_next_state = S_READ;
      end
      S_READ: begin
        // Losing halt_ack means the core resumed and may be writing the file.
        if (!halt_ack) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_load_beat  = 1'b1;
          w_next_state = S_SEND;
        end
      end
      S_SEND: begin
        if (!halt_ack) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_dump_valid && dump_ready) begin
          w_handshake  = 1'b1;
          w_next_state = r_dump_last ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_last_idx   <= '0;
      r_halt_req   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_index <= '0;
      r_dump_data  <= '0;
      r_dump_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (r_state == S_DONE);
      r_err   <= w_reject | w_abort;

      if (w_accept) begin
        r_idx      <= first_idx;
        r_last_idx <= last_idx;
        r_halt_req <= 1'b1;
      end

      if (w_load_beat) begin
        r_dump_data  <= rf_read_data;
        r_dump_index <= r_idx;
        r_dump_last  <= (r_idx == r_last_idx);
        r_dump_valid <= 1'b1;
      end

      // The walk stops at last_idx, so the increment never wraps.
      if (w_handshake) begin
        r_dump_valid <= 1'b0;
        if (!r_dump_last) r_idx <= r_idx + 1'b1;
      end

      if (w_abort || r_state == S_DONE) begin
        r_dump_valid <= 1'b0;
        r_halt_req   <= 1'b0;
        r_idx        <= '0;
      end
    end
  end

  assign halt_req    = r_halt_req;
  assign rf_read_reg = r_idx;
  assign dump_valid  = r_dump_valid;
  assign dump_index  = r_dump_index;
  assign dump_data   = r_dump_data;
  assign dump_last   = r_dump_last;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the CPU register file. On a start request it halts the core, walks a programmed index range through one register-file read port, and streams each {index, data} pair to a debug sink over a valid/ready handshake. When the range is finished it releases the halt. It sits between the debug controller and the register file's read-port mux, and is the consumer end of the register file's asynchronous read interface.

## Interface
- ADDR_W, 5: register index width (32 registers).
- DATA_W, 32: register data width.

- clk  in  1  clock.
- rst  in  1  reset (synchronous, active-high).
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_idx  in  ADDR_W  first register index, latched on accepted start.
- last_idx  in  ADDR_W  last register index (inclusive), latched on accepted start.
- halt_req  out  1  core halt request; held high from accepted start until DONE or abort.
- halt_ack  in  1  core is halted and not writing the register file; must stay high while halt_req is high.
- rf_read_reg  out  ADDR_W  register-file read address (combinational read port).
- rf_read_data  in  DATA_W  register-file read data for rf_read_reg, same cycle.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts beat.
- dump_index  out  ADDR_W  index of current beat.
- dump_data  out  DATA_W  register value of current beat.
- dump_last  out  1  current beat is last_idx.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on rejected start (first_idx > last_idx) or halt_ack loss.

## Operation
- States: IDLE, HALT_WAIT, READ, SEND, DONE.
- IDLE:
  - start with first_idx <= last_idx: latch both indices, set idx = first_idx, set halt_req = 1, go to HALT_WAIT.
  - start with first_idx > last_idx: pulse err and stay in IDLE; halt_req is not raised.
- HALT_WAIT: wait indefinitely for halt_ack = 1, then go to READ.
- READ: rf_read_reg = idx. At the clock edge, register dump_data <= rf_read_data, dump_index <= idx, dump_last <= (idx == last_idx), dump_valid <= 1. Go to SEND.
- SEND:
  - Hold dump_valid, dump_data, dump_index and dump_last stable until dump_valid && dump_ready.
  - On handshake, clear dump_valid. If dump_last, go to DONE. Otherwise idx <= idx + 1 and go to READ.
  - idx never wraps, because the walk ends at last_idx (last_idx = 31 ends at 31).
- DONE: clear halt_req, pulse done, reset idx to 0, go to IDLE.
- Abort: halt_ack = 0 while in READ or SEND means the core resumed. Pulse err, clear dump_valid, halt_req and idx, and go to IDLE. No further beats are sent, and done is not pulsed.
- start in any non-IDLE state is ignored (no queueing).
- rf_read_reg = idx in all states. It is 0 in IDLE.
- first_idx == last_idx produces exactly one beat with dump_last = 1.

## Timing
- All outputs are registered except rf_read_reg (driven directly from the idx register).
- Reset values: halt_req 0, rf_read_reg 0, dump_valid 0, dump_index 0, dump_data 0, dump_last 0, busy 0, done 0, err 0. State is IDLE.
- rst mid-dump takes effect at the next edge and returns to the reset values. The halt is released immediately, and any in-flight beat is dropped.
- Latency example with start at edge E0 and halt_ack already high:
  - halt_req is high after E0.
  - READ is entered after E1.
  - The first dump_valid is high after E2.
- Throughput: one beat per 2 cycles with dump_ready held high. Each additional cycle dump_ready is low adds one cycle.
- Total for N beats with dump_ready tied high: done pulses 2N+2 cycles after the start edge.
- halt_req drops and done pulses on the same cycle, the cycle after the last handshake.
- err is a one-cycle pulse, on the cycle after the triggering condition.

## Test plan
- Full dump: preload reg i = 0x1000_0100 + i, start with range 0..31, halt_ack and dump_ready tied high -> 32 beats with indices 0..31 and matching data, dump_last only on index 31, done pulse 66 cycles after start, halt_req low afterwards.
- Backpressure: range 4..6, dump_ready toggled 1/0 pseudo-randomly -> exactly 3 beats, and dump_data/dump_index never change while valid && !ready.
- Single register and bad range: range 7..7 -> one beat, index 7, dump_last = 1. Range 9..3 -> err pulse, no halt_req, busy stays 0.
- Delayed ack: halt_ack asserted 10 cycles after start -> no dump_valid before ack. The first beat appears 2 cycles after the ack edge. start pulses during the dump are ignored.
- Abort: halt_ack dropped during SEND of index 2 in range 0..5 -> err pulse, dump_valid and halt_req low the next cycle, no done pulse. A subsequent start works normally.
- Reset mid-dump: rst asserted during beat 3 -> all outputs at reset values after one edge. A new start after rst deasserts completes correctly.
